// File: rtl/turf_header_generator_v3_if.sv
// AXI-Stream style header channel between the TURF header generator and its consumer.
interface turf_header_generator_v3_if;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/turf_header_generator_v3.sv
// Builds the TURF event header: on an accepted trigger it latches timestamps, gathers
// per-channel metadata over a short window, then streams the header out as 64-bit qwords.
module turf_header_generator_v3 #(
    parameter int NUM_META    = 32,
    parameter int META_BITS   = 8,
    parameter int META_WINDOW = 16,
    parameter int HDR_QWORDS  = 16
) (
    input  logic                          sysclk_i,
    input  logic                          rst_i,
    input  logic                          runrst_i,
    input  logic                          runstop_i,
    input  logic [3:0]                    tio_mask_i,
    input  logic [11:0]                   runcfg_i,
    input  logic                          trig_i,
    input  logic [NUM_META*META_BITS-1:0] metadata_i,
    input  logic [31:0]                   cur_sec_i,
    input  logic [31:0]                   cur_time_i,
    input  logic [31:0]                   last_pps_i,
    input  logic [31:0]                   llast_pps_i,
    turf_header_generator_v3_if.master    m_thdr,
    output logic                          event_o,
    output logic                          busy_o,
    output logic [15:0]                   dropped_o
);

    localparam int META_W  = NUM_META * META_BITS;
    localparam int META_QW = META_W / 64;
    localparam int QW_BITS = $clog2(HDR_QWORDS);
    localparam logic [QW_BITS-1:0] LAST_QW  = QW_BITS'(HDR_QWORDS - 1);
    localparam logic [7:0]         WIN_LAST = 8'(META_WINDOW - 1);
    localparam logic [15:0]        HDR_LEN  = 16'(HDR_QWORDS * 4 - 1);
    localparam logic [15:0]        HDR_TAG  = 16'h4532;

    typedef enum logic [1:0] {IDLE, WINDOW, EMIT} state_t;

    state_t state, next_state;

    logic               running;
    logic [31:0]        event_counter;
    logic [3:0]         run_mask;
    logic [11:0]        run_cfg;
    logic [31:0]        hdr_event, hdr_sec, hdr_time, hdr_pps, hdr_lpps;
    logic [3:0]         hdr_mask;
    logic [11:0]        hdr_cfg;
    logic [META_W-1:0]  meta_hold;
    logic [7:0]         win_cnt;
    logic [QW_BITS-1:0] qword_idx;

    logic accept, drop, capture, handshake, last_beat;

    // A run reset in the same cycle as a trigger takes precedence and swallows the trigger.
    always_comb begin
        accept    = running && (state == IDLE) && trig_i && !runrst_i;
        drop      = running && (state != IDLE) && trig_i && !runrst_i;
        capture   = (state == WINDOW) && (win_cnt < WIN_LAST);
        handshake = (state == EMIT) && m_thdr.tready;
        last_beat = handshake && (qword_idx == LAST_QW);
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)              next_state = WINDOW;
            WINDOW:  if (win_cnt == WIN_LAST) next_state = EMIT;
            EMIT:    if (last_beat)           next_state = IDLE;
            default:                          next_state = IDLE;
        endcase
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            running       <= 1'b0;
            event_counter <= '0;
            dropped_o     <= '0;
            run_mask      <= '0;
            run_cfg       <= '0;
        end else begin
            if (runrst_i) begin
                running       <= 1'b1;
                event_counter <= '0;
                dropped_o     <= '0;
                run_mask      <= tio_mask_i;
                run_cfg       <= runcfg_i;
            end else begin
                if (runstop_i) running <= 1'b0;
                if (accept) event_counter <= event_counter + 32'd1;
                if (drop && (dropped_o != 16'hFFFF)) dropped_o <= dropped_o + 16'd1;
            end
        end
    end

    // Everything the header reports is frozen at accept so a mid-header run reset cannot corrupt it.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            event_o   <= 1'b0;
            hdr_event <= '0;
            hdr_sec   <= '0;
            hdr_time  <= '0;
            hdr_pps   <= '0;
            hdr_lpps  <= '0;
            hdr_mask  <= '0;
            hdr_cfg   <= '0;
        end else begin
            event_o <= accept;
            if (accept) begin
                hdr_event <= event_counter;
                hdr_sec   <= cur_sec_i;
                hdr_time  <= cur_time_i;
                hdr_pps   <= last_pps_i;
                hdr_lpps  <= llast_pps_i;
                hdr_mask  <= run_mask;
                hdr_cfg   <= run_cfg;
            end
        end
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            win_cnt   <= '0;
            qword_idx <= '0;
        end else begin
            if (accept) begin
                win_cnt   <= '0;
                qword_idx <= '0;
            end else begin
                if (state == WINDOW) win_cnt <= win_cnt + 8'd1;
                if (handshake && !last_beat) qword_idx <= qword_idx + QW_BITS'(1);
            end
        end
    end

    // The accept cycle itself is the first metadata sample; afterwards only still-zero channels update.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_hold <= '0;
        end else if (accept) begin
            meta_hold <= metadata_i;
        end else if (capture) begin
            for (int n = 0; n < NUM_META; n++) begin
                if (meta_hold[n*META_BITS +: META_BITS] == '0) begin
                    meta_hold[n*META_BITS +: META_BITS] <= metadata_i[n*META_BITS +: META_BITS];
                end
            end
        end
    end

    always_comb begin
        busy_o        = (state != IDLE);
        m_thdr.tvalid = (state == EMIT);
        m_thdr.tlast  = (state == EMIT) && (qword_idx == LAST_QW);
        m_thdr.tdata  = '0;
        if (state == EMIT) begin
            if (qword_idx == QW_BITS'(0)) begin
                m_thdr.tdata = {hdr_event, HDR_TAG, HDR_LEN};
            end else if (qword_idx == QW_BITS'(1)) begin
                m_thdr.tdata = {hdr_time, hdr_sec};
            end else if (qword_idx == QW_BITS'(2)) begin
                m_thdr.tdata = {hdr_lpps, hdr_pps};
            end else if (qword_idx == LAST_QW) begin
                m_thdr.tdata = {16'd64, hdr_mask, hdr_cfg, 32'h0};
            end else begin
                for (int i = 0; i < META_QW; i++) begin
                    if (qword_idx == QW_BITS'(3 + i)) m_thdr.tdata = meta_hold[i*64 +: 64];
                end
            end
        end
    end

endmodule

// File: tb/tb_turf_header_generator_v3.sv
// Randomised and directed bench for the TURF header generator, checked every cycle against a header-level model.
module tb_turf_header_generator_v3;

    localparam int NUM_META    = 32;
    localparam int META_BITS   = 8;
    localparam int META_WINDOW = 16;
    localparam int HDR_QWORDS  = 16;
    localparam int META_W      = NUM_META * META_BITS;
    localparam int META_QW     = META_W / 64;

    logic              sysclk_i = 1'b0;
    logic              rst_i = 1'b0, runrst_i = 1'b0, runstop_i = 1'b0, trig_i = 1'b0;
    logic [3:0]        tio_mask_i = '0;
    logic [11:0]       runcfg_i = '0;
    logic [META_W-1:0] metadata_i = '0;
    logic [31:0]       cur_sec_i = '0, cur_time_i = '0, last_pps_i = '0, llast_pps_i = '0;
    logic              event_o, busy_o;
    logic [15:0]       dropped_o;

    turf_header_generator_v3_if thdr ();

    turf_header_generator_v3 #(
        .NUM_META(NUM_META), .META_BITS(META_BITS),
        .META_WINDOW(META_WINDOW), .HDR_QWORDS(HDR_QWORDS)
    ) dut (
        .sysclk_i(sysclk_i), .rst_i(rst_i), .runrst_i(runrst_i), .runstop_i(runstop_i),
        .tio_mask_i(tio_mask_i), .runcfg_i(runcfg_i), .trig_i(trig_i), .metadata_i(metadata_i),
        .cur_sec_i(cur_sec_i), .cur_time_i(cur_time_i), .last_pps_i(last_pps_i),
        .llast_pps_i(llast_pps_i), .m_thdr(thdr), .event_o(event_o), .busy_o(busy_o),
        .dropped_o(dropped_o)
    );

    always #5 sysclk_i = ~sysclk_i;

    int     tests_run = 0;
    int     tests_failed = 0;
    longint edge_count = 0;
    int     tready_mode = 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Consumer back-pressure: 0 stalled, 1 always ready, 2 repeating 1-0-0-1, 3 random.
    always @(negedge sysclk_i) begin
        case (tready_mode)
            0:       thdr.tready = 1'b0;
            1:       thdr.tready = 1'b1;
            2:       thdr.tready = (edge_count % 4 == 0) || (edge_count % 4 == 3);
            default: thdr.tready = 1'($urandom_range(0, 1));
        endcase
        cur_sec_i   = $urandom;
        cur_time_i  = $urandom;
        last_pps_i  = $urandom;
        llast_pps_i = $urandom;
    end

    // Reference model state: run bookkeeping plus the header currently owed to the consumer.
    bit                 m_running, m_busy, m_tv, m_ev;
    bit [31:0]          m_evcnt;
    int                 m_dropped;
    bit [3:0]           m_mask, h_mask;
    bit [11:0]          m_cfg, h_cfg;
    bit [31:0]          h_ev, h_sec, h_time, h_pps, h_lpps;
    bit [META_BITS-1:0] m_cap [NUM_META];
    longint             m_T;
    int                 m_qidx;

    logic [63:0] beats[$];
    bit          beat_last[$];
    longint      beat_cyc[$];
    longint      event_cyc[$];
    int          tlast_seen = 0;
    logic [63:0] prev_tdata = '0;
    logic        prev_tvalid = 1'b0, prev_tlast = 1'b0;

    function automatic logic [63:0] expected_qword(input int idx);
        logic [63:0] w;
        w = '0;
        if (idx == 0) w = {h_ev, 16'h4532, 16'(HDR_QWORDS * 4 - 1)};
        else if (idx == 1) w = {h_time, h_sec};
        else if (idx == 2) w = {h_lpps, h_pps};
        else if (idx == HDR_QWORDS - 1) w = {16'd64, h_mask, h_cfg, 32'h0};
        else if (idx >= 3 && idx < 3 + META_QW) begin
            for (int ch = 0; ch < NUM_META; ch++) begin
                if ((ch * META_BITS) / 64 == idx - 3) w |= 64'(m_cap[ch]) << ((ch * META_BITS) % 64);
            end
        end
        return w;
    endfunction

    function automatic logic [63:0] get_beat(input int i);
        return (i < beats.size()) ? beats[i] : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    always @(posedge sysclk_i) begin
        longint e;
        bit     busy_pre;
        #1;
        edge_count++;
        e = edge_count;
        if (!rst_i && prev_tvalid && thdr.tready) begin
            beats.push_back(prev_tdata);
            beat_last.push_back(prev_tlast);
            beat_cyc.push_back(e);
            if (prev_tlast) tlast_seen++;
        end
        if (event_o === 1'b1) event_cyc.push_back(e + 1);
        m_ev = 1'b0;
        if (rst_i) begin
            m_running = 0; m_busy = 0; m_evcnt = 0; m_dropped = 0;
            m_mask = 0; m_cfg = 0; m_qidx = 0;
            for (int ch = 0; ch < NUM_META; ch++) m_cap[ch] = '0;
        end else begin
            busy_pre = m_busy;
            if (m_tv && thdr.tready) begin
                if (m_qidx == HDR_QWORDS - 1) m_busy = 0;
                else m_qidx++;
            end
            if (busy_pre && e > m_T && e <= m_T + META_WINDOW - 1) begin
                for (int ch = 0; ch < NUM_META; ch++)
                    if (m_cap[ch] == '0) m_cap[ch] = metadata_i[ch*META_BITS +: META_BITS];
            end
            if (runrst_i) begin
                m_running = 1; m_evcnt = 0; m_dropped = 0;
                m_mask = tio_mask_i; m_cfg = runcfg_i;
            end else if (trig_i && m_running) begin
                if (!busy_pre) begin
                    m_T = e; m_ev = 1; m_busy = 1; m_qidx = 0;
                    h_ev = m_evcnt; h_sec = cur_sec_i; h_time = cur_time_i;
                    h_pps = last_pps_i; h_lpps = llast_pps_i; h_mask = m_mask; h_cfg = m_cfg;
                    m_evcnt++;
                    for (int ch = 0; ch < NUM_META; ch++) m_cap[ch] = metadata_i[ch*META_BITS +: META_BITS];
                end else if (m_dropped < 65535) begin
                    m_dropped++;
                end
            end
            if (runstop_i && !runrst_i) m_running = 0;
        end
        m_tv = m_busy && (e >= m_T + META_WINDOW);
        check_output("event_o", 64'(event_o), 64'(m_ev));
        check_output("busy_o", 64'(busy_o), 64'(m_busy));
        check_output("tvalid", 64'(thdr.tvalid), 64'(m_tv));
        check_output("tlast", 64'(thdr.tlast), 64'(m_tv && (m_qidx == HDR_QWORDS - 1)));
        check_output("dropped_o", 64'(dropped_o), 64'(m_dropped));
        if (m_tv) check_output("tdata", thdr.tdata, expected_qword(m_qidx));
        prev_tvalid = thdr.tvalid;
        prev_tdata  = thdr.tdata;
        prev_tlast  = thdr.tlast;
    end

    task automatic apply_stimulus(input bit rr, input bit rs, input bit tg);
        runrst_i = rr; runstop_i = rs; trig_i = tg;
        @(negedge sysclk_i);
        runrst_i = 1'b0; runstop_i = 1'b0; trig_i = 1'b0;
    endtask

    task automatic clear_logs();
        beats.delete(); beat_last.delete(); beat_cyc.delete(); event_cyc.delete();
    endtask

    task automatic wait_done(input int budget);
        int start;
        start = tlast_seen;
        for (int i = 0; i < budget; i++) begin
            if (tlast_seen > start) return;
            @(negedge sysclk_i);
        end
        check_output("header_timeout", 64'(tlast_seen > start), 64'd1);
    endtask

    initial begin
        longint t0;
        logic [15:0] last_mask;
        logic [63:0] q3;

        rst_i = 1'b1;
        repeat (3) @(negedge sysclk_i);
        check_output("reset_outputs", {thdr.tdata[31:0], 7'd0, thdr.tvalid, 7'd0, thdr.tlast, 7'd0, event_o, 7'd0, busy_o},
                     64'd0);
        check_output("reset_dropped", 64'(dropped_o), 64'd0);
        rst_i = 1'b0;
        @(negedge sysclk_i);

        // Basic header timing and content, with channel 5 metadata changing across the window.
        tready_mode = 1;
        tio_mask_i = 4'hA; runcfg_i = 12'h5C3;
        apply_stimulus(1, 0, 0);
        clear_logs();
        t0 = edge_count + 1;
        for (int k = 0; k <= 20; k++) begin
            metadata_i[5*META_BITS +: META_BITS] = (k >= 16) ? 8'h11 : (k >= 4) ? 8'h7F : (k >= 2) ? 8'h3A : 8'h00;
            trig_i = (k == 0);
            @(negedge sysclk_i);
        end
        trig_i = 1'b0;
        wait_done(60);
        check_output("event_cycle", (event_cyc.size() > 0) ? 64'(event_cyc[0]) : 64'd0, 64'(t0 + 1));
        check_output("beat_count_a", 64'(beats.size()), 64'd16);
        check_output("first_beat_cycle", (beat_cyc.size() > 0) ? 64'(beat_cyc[0]) : 64'd0, 64'(t0 + 17));
        check_output("qword0_a", get_beat(0), 64'h0000_0000_4532_003F);
        q3 = get_beat(3);
        check_output("meta_ch5", 64'(q3[47:40]), 64'h3A);
        last_mask = '0;
        for (int i = 0; i < beat_last.size() && i < 16; i++) last_mask[i] = beat_last[i];
        check_output("tlast_position", 64'(last_mask), 64'h8000);
        check_output("trailer_a", get_beat(15), 64'h0040_A5C3_0000_0000);

        // Back-pressure pattern 1-0-0-1 throughout the header.
        for (int ch = 0; ch < NUM_META; ch++)
            metadata_i[ch*META_BITS +: META_BITS] = ($urandom_range(0, 2) == 0) ? META_BITS'($urandom) : '0;
        clear_logs();
        tready_mode = 2;
        apply_stimulus(0, 0, 1);
        wait_done(120);
        tready_mode = 1;
        @(negedge sysclk_i);
        check_output("beat_count_b", 64'(beats.size()), 64'd16);
        check_output("qword0_b", get_beat(0), 64'h0000_0001_4532_003F);

        // Triggers during WINDOW and EMIT are dropped and counted.
        apply_stimulus(1, 0, 0);
        clear_logs();
        for (int k = 0; k <= 25; k++) begin
            trig_i = (k == 0) || (k == 3) || (k == 10) || (k == 20);
            @(negedge sysclk_i);
        end
        trig_i = 1'b0;
        wait_done(60);
        check_output("qword0_c", get_beat(0), 64'h0000_0000_4532_003F);
        check_output("dropped_three", 64'(dropped_o), 64'd3);
        clear_logs();
        apply_stimulus(0, 0, 1);
        wait_done(60);
        check_output("qword0_c2", get_beat(0), 64'h0000_0001_4532_003F);

        // Run stop in the middle of a header.
        clear_logs();
        apply_stimulus(0, 0, 1);
        for (int i = 0; i < 60 && beats.size() < 7; i++) @(negedge sysclk_i);
        check_output("reached_qword7", 64'(beats.size() >= 7), 64'd1);
        apply_stimulus(0, 1, 0);
        wait_done(60);
        check_output("beat_count_d", 64'(beats.size()), 64'd16);
        check_output("qword0_d", get_beat(0), 64'h0000_0002_4532_003F);
        repeat (3) begin
            apply_stimulus(0, 0, 1);
            @(negedge sysclk_i);
        end
        repeat (5) @(negedge sysclk_i);
        check_output("events_after_stop", 64'(event_cyc.size()), 64'd1);
        check_output("dropped_after_stop", 64'(dropped_o), 64'd3);

        // Randomised traffic, back-pressure, run resets and stops.
        tio_mask_i = 4'($urandom); runcfg_i = 12'($urandom);
        apply_stimulus(1, 0, 0);
        tready_mode = 3;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 199);
            trig_i = ($urandom_range(0, 7) == 0);
            runrst_i = (r == 0) || (r == 2);
            runstop_i = (r == 1);
            tio_mask_i = 4'($urandom); runcfg_i = 12'($urandom);
            for (int ch = 0; ch < NUM_META; ch++)
                metadata_i[ch*META_BITS +: META_BITS] = ($urandom_range(0, 3) == 0) ? META_BITS'($urandom) : '0;
            @(negedge sysclk_i);
        end
        trig_i = 1'b0; runrst_i = 1'b0; runstop_i = 1'b0;
        tready_mode = 1;
        repeat (60) @(negedge sysclk_i);

        // Asynchronous reset while the header is being emitted.
        apply_stimulus(1, 0, 0);
        for (int k = 0; k <= 7; k++) begin
            trig_i = (k == 0) || (k == 2) || (k == 5);
            @(negedge sysclk_i);
        end
        trig_i = 1'b0;
        for (int i = 0; i < 40 && thdr.tvalid !== 1'b1; i++) @(negedge sysclk_i);
        check_output("reached_emit", 64'(thdr.tvalid), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check_output("async_tvalid", 64'(thdr.tvalid), 64'd0);
        check_output("async_busy", 64'(busy_o), 64'd0);
        check_output("async_dropped", 64'(dropped_o), 64'd0);
        repeat (2) @(negedge sysclk_i);
        rst_i = 1'b0;
        apply_stimulus(1, 0, 0);
        clear_logs();
        apply_stimulus(0, 0, 1);
        wait_done(60);
        check_output("qword0_after_reset", get_beat(0), 64'h0000_0000_4532_003F);

        // Drop counter saturation with the consumer stalled.
        tready_mode = 0;
        apply_stimulus(1, 0, 0);
        trig_i = 1'b1;
        repeat (65545) @(negedge sysclk_i);
        trig_i = 1'b0;
        check_output("dropped_saturated", 64'(dropped_o), 64'hFFFF);
        tready_mode = 1;
        wait_done(60);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/turf_header_generator_v3.md
TURF_HEADER_GENERATOR_V3 -- requirements
Module: turf_header_generator_v3

Interface
REQ-001 Parameter NUM_META, default 32, number of metadata channels.
REQ-002 Parameter META_BITS, default 8, bits per metadata channel; NUM_META*META_BITS SHALL be a multiple of 64.
REQ-003 Parameter META_WINDOW, default 16, metadata capture window in clocks, range 1..255.
REQ-004 Parameter HDR_QWORDS, default 16, header length in 64-bit qwords; SHALL be at least 4 + NUM_META*META_BITS/64.
REQ-005 sysclk_i  in  1  sole clock; all logic on its rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 runrst_i  in  1  run start: sets running, clears counters, latches run config.
REQ-008 runstop_i  in  1  run stop: clears running.
REQ-009 tio_mask_i  in  4  TURFIO mask, latched on runrst_i.
REQ-010 runcfg_i  in  12  run configuration, latched on runrst_i.
REQ-011 trig_i  in  1  trigger pulse.
REQ-012 metadata_i  in  NUM_META*META_BITS  channel metadata; channel n is bits [n*META_BITS +: META_BITS].
REQ-013 cur_sec_i, cur_time_i, last_pps_i, llast_pps_i  in  32 each  timestamps.
REQ-014 m_thdr_tdata  out  64  header qword.
REQ-015 m_thdr_tvalid  out  1;  m_thdr_tready  in  1;  m_thdr_tlast  out  1  last qword of header.
REQ-016 event_o  out  1  one-cycle pulse per accepted trigger.
REQ-017 busy_o  out  1  high when state is not IDLE.
REQ-018 dropped_o  out  16  count of triggers rejected while busy.

Function
REQ-019 States: IDLE, WINDOW, EMIT; IDLE->WINDOW on accepted trigger; WINDOW->EMIT after META_WINDOW cycles; EMIT->IDLE on handshake (tvalid & tready) of qword HDR_QWORDS-1.
REQ-020 Trigger is accepted only when running, state IDLE, and runrst_i low; on accept cycle T, cur_sec/cur_time/last_pps/llast_pps and event_counter are latched, and event_o pulses in cycle T+1.
REQ-021 Metadata capture samples cycles T..T+META_WINDOW-1; per channel, the first nonzero value seen is held; channels never nonzero hold zero; holding cleared on accept.
REQ-022 m_thdr_tvalid first asserts in cycle T+META_WINDOW+1 and stays high until the final qword handshake.
REQ-023 Qword 0 = {event_counter[31:0], "E2", 16'(HDR_QWORDS*4-1)}; qword 1 = {cur_time, cur_sec}; qword 2 = {llast_pps, last_pps}.
REQ-024 Qwords 3..3+NUM_META*META_BITS/64-1 = metadata, channel 0 in bits [META_BITS-1:0] of qword 3, ascending.
REQ-025 Remaining qwords zero except qword HDR_QWORDS-1 = {16'd64, tio_mask, runcfg, 32'h0}, with m_thdr_tlast high only on it.
REQ-026 While tvalid high and tready low, tdata and tlast SHALL hold stable; qword index advances only on handshake.
REQ-027 event_counter increments by one per accepted trigger, first event is 0, wraps 0xFFFFFFFF->0.
REQ-028 Trigger while running and not IDLE increments dropped_o, saturating at 0xFFFF; triggers while not running are ignored and not counted.
REQ-029 runrst_i together with trig_i: runrst_i wins, trigger ignored and not counted.
REQ-030 runstop_i mid-header: the in-progress header completes in full; no new trigger accepted afterwards.
REQ-031 runrst_i mid-header: counters and config update, in-progress header completes with values latched at its trigger.

Reset
REQ-032 rst_i asynchronously forces state IDLE, running 0, m_thdr_tvalid 0, m_thdr_tlast 0, m_thdr_tdata 0, event_o 0, busy_o 0, dropped_o 0, event_counter 0, run config 0, metadata holding 0.

Verification
REQ-033 runrst_i, trig_i at T, tready=1 -> event_o at T+1, 16 qwords at T+17..T+32, qword0 = {0x00000000,"E2",0x003F}, tlast on qword 15 only.
REQ-034 Channel 5 = 0x00 at T, 0x3A at T+2, 0x7F at T+4, 0x11 at T+16 -> qword 3 bits [47:40] = 0x3A.
REQ-035 tready toggled 1-0-0-1 throughout -> all 16 qwords delivered in order, tdata stable during stalls, no duplicates.
REQ-036 Trigger at T, three triggers during WINDOW/EMIT -> one header, dropped_o = 3; next accepted header has event_counter 1; after 65540 drops dropped_o = 0xFFFF.
REQ-037 runstop_i at qword 7 -> header completes through tlast; subsequent trig_i produces no event_o, dropped_o unchanged.
REQ-038 rst_i asserted mid-EMIT without clock edge -> tvalid, busy_o, dropped_o immediately 0; after release and runrst_i, first header event_counter = 0.
